hen_uio_arbiter: RTL and testbench
==================================

Name: hen_uio_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the bidirectional uio bus of the hen top level between NREQ internal requesters.
- Each requester issues a burst of len+1 byte beats, either driving the bus (write) or sampling it (read).
- Controls uio_oe, inserts bus-turnaround cycles on direction change, and returns read bytes with a valid strobe.
- Sits between the hen core datapath and the uio_in/uio_out/uio_oe pins.

Parameters:
- NREQ, 3, number of requesters (2..4).
- LEN_W, 4, width of burst length field; a burst is len+1 beats (1..16).
- TURN_CYC, 1, turnaround cycles (uio_oe=0) inserted on direction change (1..3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- ena  in  1  design enable; low blocks new grants.
- req  in  NREQ  per-requester burst request; held until grant.
- req_dir  in  NREQ  per-requester direction, 1=write (drive bus), 0=read.
- req_len  in  NREQ*LEN_W  per-requester beats minus one, packed with requester 0 in the LSBs.
- req_wdata  in  NREQ*8  per-requester write byte, packed with requester 0 in the LSBs.
- grant  out  NREQ  one-hot owner of the bus, held for the whole burst including turnaround.
- beat_ack  out  1  high in each transfer-beat cycle; the owner advances wdata on it.
- rd_data  out  8  registered uio_in sample.
- rd_valid  out  1  one-cycle strobe, rd_data valid.
- busy  out  1  state != IDLE.
- uio_in  in  8  bus input path.
- uio_out  out  8  bus output path.
- uio_oe  out  8  bus enable, 8'hFF for write beats, else 8'h00.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State=IDLE, grant=0, beat_ack=0, rd_data=0, rd_valid=0, busy=0, uio_out=0, uio_oe=0.
  - rr_ptr=0, last_dir=0 (read), beat counter=0.
  - Reset overrides a burst in progress; no further beats occur.
- States: IDLE, TURN, XFER.
- IDLE:
  - If ena=1 and any req bit is set, pick the winner: the first set bit searching from rr_ptr upward, wrapping.
  - On that edge, register grant=onehot(winner) and latch cnt=req_len[winner] and dir=req_dir[winner].
  - If dir != last_dir, go to TURN with tcnt=TURN_CYC-1; otherwise go to XFER.
  - Request-to-grant latency is 1 cycle.
- TURN:
  - uio_oe=0, beat_ack=0.
  - Decrement tcnt; at 0 go to XFER and set last_dir=dir.
- XFER:
  - beat_ack=1 every cycle.
  - Write: uio_oe=8'hFF, uio_out=req_wdata[winner], combinational from the latched grant, so there is no extra latency.
  - Read: uio_oe=0; on the same edge rd_data<=uio_in, and rd_valid=1 in the following cycle.
  - cnt decrements per beat. At the edge where cnt==0: go to IDLE, grant=0, rr_ptr=winner+1 mod NREQ.
- Gap between bursts: at least one IDLE cycle; uio_oe drops to 0 in that cycle.
- uio_out outside write beats: 8'h00.
- In-flight behaviour:
  - req, req_dir and req_len changes after grant are ignored; the burst always runs len+1 beats.
  - ena falling mid-burst does not abort; the current burst completes and no new grant is issued while ena=0.
- Simultaneous requests: resolved strictly by rr_ptr; a requester that just finished has lowest priority next.
- No starvation: every continuously asserted req is granted within NREQ bursts.
- Invariants:
  - grant is zero or one-hot.
  - uio_oe is never 8'hFF in TURN or IDLE.
  - uio_oe is never 8'hFF in the cycle immediately after a read beat.

Decomposition:
- Shared package hen_pkg: state enum (IDLE, TURN, XFER), DIR_READ=0/DIR_WRITE=1, OE_ALL=8'hFF, OE_NONE=8'h00.
- One natural sub-module: hen_rr_pick, a combinational round-robin priority picker taking req and rr_ptr and producing onehot winner, index and any. It is reused by other hen arbiters.

Test Plan:
- Single write from reset: req=3'b001, dir=1, len=2, wdata 0xA1,0xA2,0xA3 advanced on beat_ack.
  - Required: grant=001 one cycle later, one TURN cycle with uio_oe=0.
  - Then 3 beats with uio_oe=FF and uio_out A1,A2,A3.
  - Then IDLE with grant=0 and uio_oe=0.
- Read burst: req=3'b010, dir=0, len=1, uio_in 0x5C then 0x3D.
  - Required: no TURN (last_dir=read after reset).
  - rd_valid pulses twice with rd_data 5C then 3D, each one cycle after its beat.
- Round robin: req=3'b111 held constant, all reads, len=0.
  - Required: grant sequence 001,010,100,001 with one IDLE cycle between grants.
- Direction change: write (len=0) from requester 0, then read from requester 1, with TURN_CYC=2.
  - Required: 2 TURN cycles with uio_oe=0 before the read beat.
- Reset mid-burst: write len=15, rst_n low at beat 5.
  - Required: next cycle grant=0, uio_oe=0, busy=0, rr_ptr=0.
- ena gating: burst running, ena=0 with another req pending.
  - Required: the current burst completes and no grant is issued until ena=1; then grant follows 1 cycle later.

Source files
------------

// File: rtl/hen_pkg.sv
// Shared definitions for the hen uio bus arbiters.
//   state_e   : sequencer states (idle, bus turnaround, data transfer)
//   DIR_*     : requester direction encoding
//   OE_*      : uio_oe patterns for driven / released bus
package hen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  localparam logic [7:0] OE_ALL  = 8'hFF;
  localparam logic [7:0] OE_NONE = 8'h00;

endpackage

// File: rtl/hen_rr_pick.sv
// Combinational round-robin priority picker.
//   req    : request vector
//   ptr    : index with highest priority; search runs upward and wraps
//   onehot : one-hot winner (zero when no request)
//   idx    : winner index (zero when no request)
//   any    : at least one request present
module hen_rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = IW'((32'(ptr) + off) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/hen_uio_arbiter.sv
// Round-robin arbiter/sequencer sharing the bidirectional uio bus between
// NREQ requesters. Each granted requester runs a burst of len+1 beats, either
// driving the bus (write) or sampling it (read). Turnaround cycles with the
// bus released are inserted whenever the direction changes.
//   clk, rst_n   : clock, synchronous active-low reset
//   ena          : enable; low blocks new grants (running burst completes)
//   req/req_dir  : per-requester request and direction (1=write, 0=read)
//   req_len      : per-requester beats-minus-one, requester 0 in LSBs
//   req_wdata    : per-requester write byte, requester 0 in LSBs
//   grant        : one-hot bus owner for the whole burst incl. turnaround
//   beat_ack     : high in each transfer beat; owner advances wdata on it
//   rd_data/rd_valid : registered uio_in sample and its one-cycle strobe
//   busy         : sequencer not idle
//   uio_in/uio_out/uio_oe : bus pins
module hen_uio_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_dir,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ*8-1:0]       req_wdata,
  output logic [NREQ-1:0]         grant,
  output logic                    beat_ack,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  input  logic [7:0]              uio_in,
  output logic [7:0]              uio_out,
  output logic [7:0]              uio_oe
);

  import hen_pkg::*;

  localparam int unsigned IW = $clog2(NREQ);

  state_e            state_q,    state_d;
  logic [NREQ-1:0]   grant_q,    grant_d;
  logic [IW-1:0]     win_q,      win_d;
  logic [IW-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [LEN_W-1:0]  cnt_q,      cnt_d;
  logic              dir_q,      dir_d;
  logic              last_dir_q, last_dir_d;
  logic [1:0]        tcnt_q,     tcnt_d;
  logic [7:0]        rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              wr_beat;

  hen_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    win_d      = win_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    tcnt_d     = tcnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ena && pick_any) begin
          grant_d = pick_onehot;
          win_d   = pick_idx;
          cnt_d   = req_len[32'(pick_idx)*LEN_W +: LEN_W];
          dir_d   = req_dir[pick_idx];
          if (req_dir[pick_idx] != last_dir_q) begin
            state_d = ST_TURN;
            tcnt_d  = 2'(TURN_CYC - 1);
          end else begin
            state_d = ST_XFER;
          end
        end
      end

      ST_TURN: begin
        if (tcnt_q == 2'd0) begin
          state_d    = ST_XFER;
          last_dir_d = dir_q;
        end else begin
          tcnt_d = tcnt_q - 2'd1;
        end
      end

      ST_XFER: begin
        if (dir_q == DIR_READ) begin
          rd_data_d  = uio_in;
          rd_valid_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          // Finished owner drops to lowest priority for the next pick.
          rr_ptr_d = (32'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      win_q      <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_READ;
      last_dir_q <= DIR_READ;
      tcnt_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      win_q      <= win_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      tcnt_q     <= tcnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Write data is muxed straight from the live owner input, so the owner's
  // wdata update on beat_ack appears on the bus in the next beat.
  assign wr_beat  = (state_q == ST_XFER) && (dir_q == DIR_WRITE);
  assign uio_oe   = wr_beat ? OE_ALL : OE_NONE;
  assign uio_out  = wr_beat ? req_wdata[32'(win_q)*8 +: 8] : 8'h00;
  assign grant    = grant_q;
  assign beat_ack = (state_q == ST_XFER);
  assign busy     = (state_q != ST_IDLE);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_hen_uio_arbiter.sv
module tb_hen_uio_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [2:0]  req;
  logic [2:0]  req_dir;
  logic [11:0] req_len;
  logic [23:0] req_wdata;
  logic [7:0]  uio_in;

  logic [2:0]  grant,    grant2;
  logic        beat_ack, beat_ack2;
  logic [7:0]  rd_data,  rd_data2;
  logic        rd_valid, rd_valid2;
  logic        busy,     busy2;
  logic [7:0]  uio_out,  uio_out2;
  logic [7:0]  uio_oe,   uio_oe2;

  int errors = 0;
  int checks = 0;

  hen_uio_arbiter #(
    .NREQ     (3),
    .LEN_W    (4),
    .TURN_CYC (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .req_dir   (req_dir),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .grant     (grant),
    .beat_ack  (beat_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .uio_in    (uio_in),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe)
  );

  hen_uio_arbiter #(
    .NREQ     (3),
    .LEN_W    (4),
    .TURN_CYC (2)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .req_dir   (req_dir),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .grant     (grant2),
    .beat_ack  (beat_ack2),
    .rd_data   (rd_data2),
    .rd_valid  (rd_valid2),
    .busy      (busy2),
    .uio_in    (uio_in),
    .uio_out   (uio_out2),
    .uio_oe    (uio_oe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    ena       = 1'b1;
    req       = '0;
    req_dir   = '0;
    req_len   = '0;
    req_wdata = '0;
    uio_in    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    ena       = 1'b1;
    req       = '0;
    req_dir   = '0;
    req_len   = '0;
    req_wdata = '0;
    uio_in    = 8'h5A;
    tick();
    tick();
    checks++;
    if ({grant, beat_ack, rd_data, rd_valid, busy, uio_out, uio_oe} !== 30'h0) begin
      errors++;
      $display("FAIL reset_dut: grant=%b ack=%b rd_data=%h rd_valid=%b busy=%b out=%h oe=%h, required all zero",
               grant, beat_ack, rd_data, rd_valid, busy, uio_out, uio_oe);
    end
    checks++;
    if ({grant2, beat_ack2, rd_data2, rd_valid2, busy2, uio_out2, uio_oe2} !== 30'h0) begin
      errors++;
      $display("FAIL reset_dut2: grant=%b ack=%b rd_data=%h rd_valid=%b busy=%b out=%h oe=%h, required all zero",
               grant2, beat_ack2, rd_data2, rd_valid2, busy2, uio_out2, uio_oe2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write;
    logic [7:0] b;
    do_reset();
    req       = 3'b001;
    req_dir   = 3'b001;
    req_len   = 12'h002;
    req_wdata = 24'h0000A1;
    tick();
    checks++;
    if ({grant, beat_ack, busy, uio_oe} !== {3'b001, 1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL wr_grant_turn: grant=%b ack=%b busy=%b oe=%h, required 001 0 1 00",
               grant, beat_ack, busy, uio_oe);
    end
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      b = 8'(8'hA1 + i);
      checks++;
      if ({grant, beat_ack, uio_oe, uio_out} !== {3'b001, 1'b1, 8'hFF, b}) begin
        errors++;
        $display("FAIL wr_beat%0d: grant=%b ack=%b oe=%h out=%h, required 001 1 ff %h",
                 i, grant, beat_ack, uio_oe, uio_out, b);
      end
      req_wdata[7:0] = 8'(b + 8'h01);
    end
    tick();
    checks++;
    if ({grant, beat_ack, busy, uio_oe, uio_out} !== {3'b000, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL wr_idle: grant=%b ack=%b busy=%b oe=%h out=%h, required 000 0 0 00 00",
               grant, beat_ack, busy, uio_oe, uio_out);
    end
  endtask

  task automatic test_read_burst;
    do_reset();
    req     = 3'b010;
    req_dir = 3'b000;
    req_len = 12'h010;
    uio_in  = 8'h5C;
    tick();
    checks++;
    if ({grant, beat_ack, uio_oe, rd_valid} !== {3'b010, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rd_first_beat: grant=%b ack=%b oe=%h rd_valid=%b, required 010 1 00 0",
               grant, beat_ack, uio_oe, rd_valid);
    end
    req = 3'b000;
    tick();
    checks++;
    if ({rd_valid, rd_data, beat_ack, uio_oe} !== {1'b1, 8'h5C, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL rd_data0: rd_valid=%b rd_data=%h ack=%b oe=%h, required 1 5c 1 00",
               rd_valid, rd_data, beat_ack, uio_oe);
    end
    uio_in = 8'h3D;
    tick();
    checks++;
    if ({rd_valid, rd_data, grant, beat_ack} !== {1'b1, 8'h3D, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL rd_data1: rd_valid=%b rd_data=%h grant=%b ack=%b, required 1 3d 000 0",
               rd_valid, rd_data, grant, beat_ack);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_drop: rd_valid=%b, required 0", rd_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_g [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    req     = 3'b111;
    req_dir = 3'b000;
    req_len = 12'h000;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({grant, beat_ack} !== {exp_g[i], |exp_g[i]}) begin
        errors++;
        $display("FAIL rr_cycle%0d: grant=%b ack=%b, required %b %b",
                 i, grant, beat_ack, exp_g[i], |exp_g[i]);
      end
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_dir_change;
    // dut2 has two turnaround cycles; columns are {grant, beat_ack, uio_oe}
    logic [11:0] exp_v [8] = '{
      {3'b001, 1'b0, 8'h00}, {3'b001, 1'b0, 8'h00}, {3'b001, 1'b1, 8'hFF},
      {3'b000, 1'b0, 8'h00}, {3'b010, 1'b0, 8'h00}, {3'b010, 1'b0, 8'h00},
      {3'b010, 1'b1, 8'h00}, {3'b000, 1'b0, 8'h00}};
    do_reset();
    req       = 3'b011;
    req_dir   = 3'b001;
    req_len   = 12'h000;
    req_wdata = 24'h000077;
    uio_in    = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({grant2, beat_ack2, uio_oe2} !== exp_v[i]) begin
        errors++;
        $display("FAIL dir_cycle%0d: grant/ack/oe=%h, required %h",
                 i, {grant2, beat_ack2, uio_oe2}, exp_v[i]);
      end
      if (i == 0) req = 3'b010;
      if (i == 4) req = 3'b000;
    end
    checks++;
    if ({rd_valid2, rd_data2} !== {1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL dir_rdata: rd_valid=%b rd_data=%h, required 1 c3", rd_valid2, rd_data2);
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    req     = 3'b010;
    req_dir = 3'b000;
    req_len = 12'h000;
    tick();
    checks++;
    if ({grant, beat_ack} !== {3'b010, 1'b1}) begin
      errors++;
      $display("FAIL mr_pre_read: grant=%b ack=%b, required 010 1", grant, beat_ack);
    end
    req       = 3'b001;
    req_dir   = 3'b001;
    req_len   = 12'h00F;
    req_wdata = 24'h000010;
    tick();
    tick();
    checks++;
    if ({grant, beat_ack} !== {3'b001, 1'b0}) begin
      errors++;
      $display("FAIL mr_grant: grant=%b ack=%b, required 001 0", grant, beat_ack);
    end
    req = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({grant, beat_ack, uio_oe, uio_out} !== {3'b001, 1'b1, 8'hFF, 8'h10}) begin
        errors++;
        $display("FAIL mr_beat%0d: grant=%b ack=%b oe=%h out=%h, required 001 1 ff 10",
                 i, grant, beat_ack, uio_oe, uio_out);
      end
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({grant, beat_ack, busy, uio_oe, uio_out} !== 21'h0) begin
      errors++;
      $display("FAIL mr_reset: grant=%b ack=%b busy=%b oe=%h out=%h, required all zero",
               grant, beat_ack, busy, uio_oe, uio_out);
    end
    rst_n   = 1'b1;
    req     = 3'b110;
    req_dir = 3'b000;
    req_len = 12'h000;
    tick();
    // pointer back at 0 picks requester 1; last_dir back at read skips turnaround
    checks++;
    if ({grant, beat_ack} !== {3'b010, 1'b1}) begin
      errors++;
      $display("FAIL mr_ptr_after_reset: grant=%b ack=%b, required 010 1", grant, beat_ack);
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_ena_gating;
    do_reset();
    req       = 3'b001;
    req_dir   = 3'b001;
    req_len   = 12'h002;
    req_wdata = 24'h000055;
    tick();
    checks++;
    if ({grant, beat_ack} !== {3'b001, 1'b0}) begin
      errors++;
      $display("FAIL en_grant: grant=%b ack=%b, required 001 0", grant, beat_ack);
    end
    req = 3'b010;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({grant, beat_ack, uio_oe} !== {3'b001, 1'b1, 8'hFF}) begin
        errors++;
        $display("FAIL en_beat%0d: grant=%b ack=%b oe=%h, required 001 1 ff",
                 i, grant, beat_ack, uio_oe);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({grant, busy} !== {3'b000, 1'b0}) begin
        errors++;
        $display("FAIL en_blocked%0d: grant=%b busy=%b, required 000 0", i, grant, busy);
      end
    end
    ena = 1'b1;
    tick();
    checks++;
    if ({grant, beat_ack, busy} !== {3'b010, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL en_regrant: grant=%b ack=%b busy=%b, required 010 0 1",
               grant, beat_ack, busy);
    end
    req = 3'b000;
    tick();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_round_robin();
    test_dir_change();
    test_reset_mid_burst();
    test_ena_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
